// File: rtl/jtkcpu_exgtfr_seq.sv
// jtkcpu_exgtfr_seq: EXG/TFR register move sequencer that owns the register file's single read/write ports
module jtkcpu_exgtfr_seq #(
  parameter int EXG_CYC = 8,
  parameter int TFR_CYC = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  op,
  input  logic [7:0]  postbyte,
  output logic        busy,
  output logic        done,
  output logic        ill,
  output logic [3:0]  rd_sel,
  input  logic [15:0] rd_data,
  output logic        wr_en,
  output logic [3:0]  wr_sel,
  output logic [15:0] wr_data
);
  localparam int EN = EXG_CYC < 4 ? 4 : EXG_CYC;
  localparam int TN = TFR_CYC < 2 ? 2 : TFR_CYC;
  localparam int CW = $clog2((EN > TN ? EN : TN) + 1);
  typedef enum logic [2:0] {IDLE, RD1, RD2, WR2, WR1, PAD} state_t;
  state_t r_st, w_nxt;
  logic [CW-1:0] r_cnt;
  logic r_exg, r_ill, r_wr_en;
  logic [7:0] r_pb;
  logic [3:0] r_rd_sel, r_wr_sel, w_wsel;
  logic [15:0] r_t1, r_wr_data, w_val;
  logic w_valid_op, w_accept, w_go, w_wr_next;
  function automatic logic is16(input logic [3:0] c);
    return c <= 4'd5;
  endfunction
  function automatic logic is8(input logic [3:0] c);
    return c[3:2] == 2'b10;
  endfunction
  assign busy = r_st != IDLE;
  assign done = busy && r_cnt == (r_exg ? CW'(EN) : CW'(TN));
  assign ill = r_ill;
  assign rd_sel = r_rd_sel;
  assign wr_en = r_wr_en;
  assign wr_sel = r_wr_sel;
  assign wr_data = r_wr_data;
  assign w_valid_op = op == 8'h3E || op == 8'h3F;
  // the done cycle doubles as the next instruction's sampling slot
  assign w_accept = start && (!busy || done);
  assign w_go = w_accept && w_valid_op;
  assign w_val = is8(rd_sel) ? {8'hFF, rd_data[7:0]} : is16(rd_sel) ? rd_data : 16'h0000;
  assign w_wr_next = w_nxt == WR1 || w_nxt == WR2;
  assign w_wsel = w_nxt == WR2 ? r_pb[7:4] : r_pb[3:0];
  always_comb begin
    w_nxt = r_st;
    case (r_st)
      IDLE:    w_nxt = w_go ? RD1 : IDLE;
      RD1:     w_nxt = r_exg ? RD2 : WR1;
      RD2:     w_nxt = WR2;
      WR2:     w_nxt = WR1;
      default: w_nxt = done ? (w_go ? RD1 : IDLE) : PAD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= IDLE;
    else r_st <= w_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_exg     <= 1'b0;
      r_pb      <= 8'h00;
      r_t1      <= 16'h0000;
      r_ill     <= 1'b0;
      r_rd_sel  <= 4'h0;
      r_wr_en   <= 1'b0;
      r_wr_sel  <= 4'h0;
      r_wr_data <= 16'h0000;
    end else begin
      r_ill   <= w_accept && !w_valid_op;
      r_cnt   <= w_go ? CW'(1) : busy ? r_cnt + CW'(1) : r_cnt;
      r_wr_en <= w_wr_next && (is16(w_wsel) || is8(w_wsel));
      if (w_go) begin
        r_exg    <= ~op[0];
        r_pb     <= postbyte;
        r_rd_sel <= postbyte[7:4];
      end
      if (w_nxt == RD2) r_rd_sel <= r_pb[3:0];
      if (r_st == RD1) r_t1 <= w_val;
      // WR2 carries the second read straight through; WR1 after WR2 replays T1
      if (w_wr_next) begin
        r_wr_sel  <= w_wsel;
        r_wr_data <= r_st == WR2 ? r_t1 : w_val;
      end
    end
  end
endmodule

// File: tb/tb_jtkcpu_exgtfr_seq.sv
// tb_jtkcpu_exgtfr_seq: randomized bench for the EXG/TFR sequencer against a register-file level model
module tb_jtkcpu_exgtfr_seq;
  localparam int EN = 8;
  localparam int TN = 6;
  logic clk = 0, rst_n = 0, start = 0;
  logic [7:0] op = 8'h00, postbyte = 8'h00;
  logic busy, done, ill, wr_en;
  logic [3:0] rd_sel, wr_sel, rs;
  logic [15:0] rd_data, wr_data;
  logic [15:0] rf [16];
  logic [15:0] m [16];
  logic [7:0] junk = 8'h00;
  logic tb_we = 0;
  logic [3:0] tb_sel = 4'h0;
  logic [15:0] tb_val = 16'h0000;
  logic [7:0] ops [40];
  logic [7:0] pbs [40];
  bit chain [40];
  int n_cmp = 0, n_bad = 0;
  jtkcpu_exgtfr_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .postbyte(postbyte),
    .busy(busy), .done(done), .ill(ill), .rd_sel(rd_sel), .rd_data(rd_data),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data)
  );
  always #5 clk = ~clk;
  function automatic bit v16(input logic [3:0] c);
    return c <= 4'd5;
  endfunction
  function automatic bit v8(input logic [3:0] c);
    return c >= 4'd8 && c <= 4'd11;
  endfunction
  function automatic logic [15:0] mval(input logic [3:0] c);
    return v8(c) ? {8'hFF, m[c][7:0]} : v16(c) ? m[c] : 16'h0000;
  endfunction
  // 8-bit registers expose garbage in the upper byte so the width rule is exercised
  assign rd_data = v8(rd_sel) ? {junk, rf[rd_sel][7:0]} : rf[rd_sel];
  always @(negedge clk) junk <= 8'($urandom);
  always @(posedge clk)
    if (wr_en) rf[wr_sel] <= v8(wr_sel) ? {rf[wr_sel][15:8], wr_data[7:0]} : wr_data;
    else if (tb_we) rf[tb_sel] <= tb_val;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic mw(input logic [3:0] c, input logic [15:0] v);
    if (v8(c)) m[c][7:0] = v[7:0];
    else if (v16(c)) m[c] = v;
  endtask
  task automatic setr(input logic [3:0] c, input logic [15:0] v);
    @(negedge clk);
    tb_we = 1; tb_sel = c; tb_val = v; m[c] = v;
    @(negedge clk);
    tb_we = 0;
  endtask
  task automatic kick(input logic [7:0] o, input logic [7:0] p);
    @(negedge clk);
    start = 1; op = o; postbyte = p;
    @(posedge clk);
    #1;
  endtask
  task automatic cmp_regs();
    for (int c = 0; c < 16; c++)
      if (v8(4'(c)) || v16(4'(c))) chk($sformatf("reg%0d", c), rf[c], m[c]);
  endtask
  // entered just after the start edge; leaves just after the done edge
  task automatic exec(input logic [7:0] o, input logic [7:0] p, input bit ch, input logic [7:0] no, input logic [7:0] np);
    bit exg;
    logic [3:0] a, b;
    logic [15:0] v1, v2;
    int n, nw, fw, bc, dat, wc, fc, ic;
    exg = o == 8'h3E; a = p[7:4]; b = p[3:0];
    v1 = mval(a); v2 = mval(b);
    n = exg ? EN : TN;
    nw = exg ? int'(v16(a) || v8(a)) + int'(v16(b) || v8(b)) : int'(v16(b) || v8(b));
    fw = nw == 0 ? 0 : !exg ? 2 : (v16(a) || v8(a)) ? 3 : 4;
    bc = 0; dat = 0; wc = 0; fc = 0; ic = 0;
    for (int k = 1; k <= 40 && dat == 0; k++) begin
      @(negedge clk);
      bc += int'(busy);
      ic += int'(ill);
      if (wr_en) begin
        wc++;
        if (fc == 0) fc = k;
      end
      if (done) begin
        dat = k; start = ch; op = no; postbyte = np;
      end else begin
        start = 1'($urandom); op = 8'($urandom); postbyte = 8'($urandom);
      end
    end
    if (dat == 0) start = 0;
    @(posedge clk);
    #1;
    if (!ch) start = 0;
    if (exg) begin
      mw(a, v2);
      mw(b, v1);
    end else mw(b, v1);
    chk("done_cyc", dat, n);
    chk("busy_cyc", bc, n);
    chk("wr_cnt", wc, nw);
    chk("wr_first", fc, fw);
    chk("ill_busy", ic, 0);
    cmp_regs();
  endtask
  initial begin
    for (int c = 0; c < 16; c++) setr(4'(c), 16'($urandom));
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ill", ill, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_sel", rd_sel, 0);
    chk("rst_wr_sel", wr_sel, 0);
    chk("rst_wr_data", wr_data, 0);
    @(negedge clk);
    rst_n = 1;
    setr(4'h1, 16'h1234);
    kick(8'h3F, 8'h12);
    exec(8'h3F, 8'h12, 0, 8'h00, 8'h00);
    chk("tfr_y", rf[2], 16'h1234);
    setr(4'h8, 16'h005A);
    setr(4'h9, 16'h00C3);
    kick(8'h3E, 8'h89);
    exec(8'h3E, 8'h89, 0, 8'h00, 8'h00);
    chk("exg_a", rf[8][7:0], 8'hC3);
    chk("exg_b", rf[9][7:0], 8'h5A);
    setr(4'h8, 16'h007E);
    setr(4'h1, 16'hBEEF);
    kick(8'h3E, 8'h81);
    exec(8'h3E, 8'h81, 0, 8'h00, 8'h00);
    chk("mix_x", rf[1], 16'hFF7E);
    chk("mix_a", rf[8][7:0], 8'hEF);
    kick(8'h3F, 8'h61);
    exec(8'h3F, 8'h61, 0, 8'h00, 8'h00);
    chk("inv_src", rf[1], 16'h0000);
    kick(8'h3F, 8'h16);
    exec(8'h3F, 8'h16, 0, 8'h00, 8'h00);
    rs = rd_sel;
    kick(8'h20, 8'h12);
    start = 0;
    @(negedge clk);
    chk("ill_pulse", ill, 1);
    chk("ill_busy0", busy, 0);
    chk("ill_wr", wr_en, 0);
    chk("ill_rd_sel", rd_sel, rs);
    @(negedge clk);
    chk("ill_end", ill, 0);
    chk("ill_busy1", busy, 0);
    kick(8'h3E, 8'h01);
    exec(8'h3E, 8'h01, 1, 8'h3F, 8'h45);
    exec(8'h3F, 8'h45, 0, 8'h00, 8'h00);
    setr(4'h1, 16'hA55A);
    kick(8'h3E, 8'h11);
    exec(8'h3E, 8'h11, 0, 8'h00, 8'h00);
    chk("same_x", rf[1], 16'hA55A);
    for (int i = 0; i < 40; i++) begin
      ops[i] = 8'h3E | 8'($urandom_range(0, 1));
      pbs[i] = 8'($urandom);
      chain[i] = i < 39 && $urandom_range(0, 1) == 1;
    end
    for (int i = 0; i < 40; i++) begin
      if (i == 0 || !chain[i-1]) kick(ops[i], pbs[i]);
      exec(ops[i], pbs[i], chain[i], ops[(i + 1) % 40], pbs[(i + 1) % 40]);
    end
    setr(4'h1, 16'h1111);
    setr(4'h2, 16'h2222);
    kick(8'h3E, 8'h12);
    start = 0;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    chk("rst_pre_wr", wr_en, 1);
    rst_n = 0;
    #1;
    chk("rst_wr_drop", wr_en, 0);
    chk("rst_busy_drop", busy, 0);
    chk("rst_done_drop", done, 0);
    chk("rst_wr_sel0", wr_sel, 0);
    chk("rst_wr_data0", wr_data, 0);
    chk("rst_rd_sel0", rd_sel, 0);
    mw(4'h1, 16'h2222);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("rst_idle", busy, 0);
    chk("rst_x", rf[1], 16'h2222);
    chk("rst_y", rf[2], 16'h2222);
    cmp_regs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
